// File: rtl/if_stage_if.sv
// Bundle of signals between the fetch stage, instruction memory and decode.
// Modport master is the fetch stage; modport slave is the memory/decode side.
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        output ifid_valid,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_plus4,
        output fault,
        output fault_pc,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        input  ifid_valid,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  fault,
        input  fault_pc,
        input  fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: pc register, IF/ID pipeline word with stall/flush,
// redirect handling and a sticky fault for misaligned or out-of-range fetches.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);
    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] IMEM_LIMIT = AW'(IMEM_BYTES);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          ifid_valid_q, ifid_valid_d;
    logic [AW-1:0] ifid_instr_q, ifid_instr_d;
    logic [AW-1:0] ifid_pc_q, ifid_pc_d;
    logic [AW-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] fault_pc_q, fault_pc_d;
    logic [AW-1:0] fetch_count_q, fetch_count_d;

    // Next-state and datapath; redirect outranks fetch, FAULT freezes everything.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        fault_d         = fault_q;
        fault_pc_d      = fault_pc_q;
        fetch_count_d   = fetch_count_q;

        case (state_q)
            ST_SETTLE: begin
                state_d = ST_RUN;
                if (ifid_valid_q && bus.id_ready) ifid_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = bus.redirect_pc;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (!ifid_valid_q || bus.id_ready) begin
                    if (pc_q >= IMEM_LIMIT) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_pc_d   = pc_q;
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_valid_d    = 1'b1;
                        ifid_instr_d    = bus.imem_instr;
                        ifid_pc_d       = pc_q;
                        ifid_pc_plus4_d = AW'(pc_q + 32'd4);
                        pc_d            = AW'(pc_q + 32'd4);
                        fetch_count_d   = AW'(fetch_count_q + 32'd1);
                    end
                end
            end
            ST_FAULT: begin
                if (ifid_valid_q && bus.id_ready) ifid_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_SETTLE;
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= '0;
            ifid_pc_q       <= '0;
            ifid_pc_plus4_q <= '0;
            fault_q         <= 1'b0;
            fault_pc_q      <= '0;
            fetch_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            fault_q         <= fault_d;
            fault_pc_q      <= fault_pc_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
    assign bus.fault         = fault_q;
    assign bus.fault_pc      = fault_pc_q;
    assign bus.fetch_count   = fetch_count_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, faults and reset.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] mem [0:1023];

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(4096)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_instr = (bus.imem_addr < 32'd4096) ? mem[bus.imem_addr[11:2]] : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'd0);
        chk({tag, "_instr"}, bus.ifid_instr, 32'd0);
        chk({tag, "_pc"}, bus.ifid_pc, 32'd0);
        chk({tag, "_pc4"}, bus.ifid_pc_plus4, 32'd0);
        chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
        chk({tag, "_fault_pc"}, bus.fault_pc, 32'd0);
        chk({tag, "_count"}, bus.fetch_count, 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, 32'd0);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] count);
        chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'd1);
        chk({tag, "_instr"}, bus.ifid_instr, instr);
        chk({tag, "_pc"}, bus.ifid_pc, pc);
        chk({tag, "_pc4"}, bus.ifid_pc_plus4, pc + 32'd4);
        chk({tag, "_count"}, bus.fetch_count, count);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h2001_000A;
        mem[1] = 32'h2002_0014;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'h0043_2022;
        mem[4] = 32'h0064_2824;
        mem[5] = 32'h0085_3025;
        mem[6] = 32'h00A6_3826;

        rst_n = 1'b0;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        chk_reset("rst");

        // SETTLE cycle fetches nothing
        rst_n = 1'b1;
        tick();
        chk("settle_valid", 32'(bus.ifid_valid), 32'd0);
        chk("settle_count", bus.fetch_count, 32'd0);
        chk("settle_addr", bus.imem_addr, 32'd0);

        tick();
        chk_word("seq0", 32'h2001_000A, 32'h0, 32'd1);
        tick();
        chk_word("seq1", 32'h2002_0014, 32'h4, 32'd2);

        // Stall for three cycles with ifid_pc=4
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_word("stall", 32'h2002_0014, 32'h4, 32'd2);
            chk("stall_addr", bus.imem_addr, 32'h8);
        end
        bus.id_ready = 1'b1;
        tick();
        chk_word("seq2", 32'h0022_1820, 32'h8, 32'd3);

        // Redirect to 0x14 flushes, then fetches target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h14;
        tick();
        chk("redir_valid", 32'(bus.ifid_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h14);
        chk("redir_count", bus.fetch_count, 32'd3);
        bus.redirect_valid = 1'b0;
        tick();
        chk_word("redir_tgt", 32'h0085_3025, 32'h14, 32'd4);
        chk("redir_pc4", bus.ifid_pc_plus4, 32'h18);

        // Redirect while decode stalls still flushes
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        chk("redir_stall_valid", 32'(bus.ifid_valid), 32'd0);
        chk("redir_stall_addr", bus.imem_addr, 32'h0);
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        chk_word("redir_stall_tgt", 32'h2001_000A, 32'h0, 32'd5);

        // Out-of-range: last word fetched, then fault at 0x1000
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFC;
        tick();
        chk("oor_flush", 32'(bus.ifid_valid), 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        chk_word("oor_last", 32'h0, 32'hFFC, 32'd6);
        chk("oor_pc4", bus.ifid_pc_plus4, 32'h1000);
        chk("oor_nofault", 32'(bus.fault), 32'd0);
        tick();
        chk("oor_fault", 32'(bus.fault), 32'd1);
        chk("oor_fault_pc", bus.fault_pc, 32'h1000);
        chk("oor_valid", 32'(bus.ifid_valid), 32'd0);
        chk("oor_count", bus.fetch_count, 32'd6);
        // FAULT ignores redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8;
        tick();
        tick();
        chk("fault_sticky", 32'(bus.fault), 32'd1);
        chk("fault_addr", bus.imem_addr, 32'h1000);
        chk("fault_count", bus.fetch_count, 32'd6);
        chk("fault_valid", 32'(bus.ifid_valid), 32'd0);
        bus.redirect_valid = 1'b0;

        // Reset clears fault, then reset mid-stall
        rst_n = 1'b0;
        tick();
        chk_reset("rst_fault");
        rst_n = 1'b1;
        tick();
        tick();
        chk_word("rs_fetch", 32'h2001_000A, 32'h0, 32'd1);
        bus.id_ready = 1'b0;
        tick();
        chk_word("rs_hold", 32'h2001_000A, 32'h0, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset("rst_stall");
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        tick();
        chk("rs_settle_valid", 32'(bus.ifid_valid), 32'd0);
        tick();
        chk_word("rs_first", 32'h2001_000A, 32'h0, 32'd1);

        // Misaligned redirect faults with pc held at 4
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h2;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h2);
        chk("mis_valid", 32'(bus.ifid_valid), 32'd0);
        chk("mis_addr", bus.imem_addr, 32'h4);
        tick();
        tick();
        chk("mis_addr_hold", bus.imem_addr, 32'h4);
        chk("mis_valid_hold", 32'(bus.ifid_valid), 32'd0);
        chk("mis_count", bus.fetch_count, 32'd1);

        // Redirect during SETTLE is ignored
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h14;
        tick();
        chk("settle_redir_addr", bus.imem_addr, 32'h0);
        chk("settle_redir_fault", 32'(bus.fault), 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        chk_word("settle_redir_fetch", 32'h2001_000A, 32'h0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter IMEM_BYTES, default 4096, SHALL be the instruction-memory size in bytes; addresses >= IMEM_BYTES are out of range.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 imem_addr  output  32  SHALL be the byte fetch address driven to instruction memory.
REQ-006 imem_instr  input  32  SHALL be the combinational instruction word returned for imem_addr.
REQ-007 id_ready  input  1  SHALL indicate that decode accepts the IF/ID word this cycle.
REQ-008 redirect_valid  input  1  SHALL request a branch or jump redirect this cycle.
REQ-009 redirect_pc  input  32  SHALL be the redirect target byte address.
REQ-010 ifid_valid  output  1  SHALL flag a valid IF/ID word.
REQ-011 ifid_instr  output  32  SHALL be the registered instruction.
REQ-012 ifid_pc  output  32  SHALL be the byte address of ifid_instr.
REQ-013 ifid_pc_plus4  output  32  SHALL be ifid_pc+4, modulo 2^32.
REQ-014 fault  output  1  SHALL flag a sticky fetch fault.
REQ-015 fault_pc  output  32  SHALL be the address that caused the fault.
REQ-016 fetch_count  output  32  SHALL count accepted fetches.

Function
REQ-017 The FSM SHALL have states SETTLE, RUN and FAULT.
REQ-018 SETTLE SHALL last exactly one cycle after rst_n goes high, fetch nothing, then move to RUN.
REQ-019 imem_addr SHALL equal the pc register combinationally in every state.
REQ-020 advance SHALL be (state==RUN) && !redirect_valid && (!ifid_valid || id_ready).
REQ-021 On advance: ifid_instr<=imem_instr, ifid_pc<=pc, ifid_pc_plus4<=pc+4, ifid_valid<=1, pc<=pc+4 (wraps at 2^32), fetch_count+=1 (wraps).
REQ-022 When ifid_valid && !id_ready and no redirect, all ifid_* outputs and pc SHALL hold (stall); no word is lost or duplicated.
REQ-023 When ifid_valid && id_ready and advance is false (SETTLE, FAULT or redirect cycle), ifid_valid SHALL clear.
REQ-024 Redirect SHALL have top priority in RUN: pc<=redirect_pc, ifid_valid<=0 (flush) in the same edge, no fetch that cycle; the first fetch from the target occurs the next cycle.
REQ-025 Redirect simultaneous with id_ready=0 SHALL still flush the held word.
REQ-026 If redirect_valid and redirect_pc[1:0]!=0, the block SHALL enter FAULT, set fault=1 and fault_pc=redirect_pc, and flush ifid_valid.
REQ-027 If in RUN and pc>=IMEM_BYTES at an advance point, the block SHALL enter FAULT with fault_pc=pc instead of fetching.
REQ-028 FAULT SHALL be sticky until reset: no fetches, redirect ignored, pc holds, fetch_count holds.
REQ-029 redirect_valid in SETTLE SHALL be ignored.

Reset
REQ-030 With rst_n low at a rising edge, the block SHALL set: state=SETTLE, pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0, fault=0, fault_pc=0, fetch_count=0.
REQ-031 Reset asserted mid-stall, mid-redirect or in FAULT SHALL give the REQ-030 values at the next edge, with all pending words discarded.

Verification
REQ-032 Sequential fetch: load the program {2001000A, 20020014, 00221820, ...} and hold id_ready=1 -> after SETTLE, ifid_instr = 2001000A/20020014/00221820 with ifid_pc = 0/4/8 on consecutive cycles, and fetch_count=3.
REQ-033 Stall: drop id_ready for 3 cycles while ifid_pc=4 -> ifid_instr holds 20020014 and imem_addr holds 8; on release, the next word is 00221820 @8.
REQ-034 Redirect: redirect_valid=1 with redirect_pc=0x14 while ifid_pc=8 -> the next cycle has ifid_valid=0, and the one after has ifid_instr=00853025 with ifid_pc=0x14 and ifid_pc_plus4=0x18.
REQ-035 Misaligned redirect: redirect_pc=0x2 -> fault=1 and fault_pc=0x2; ifid_valid stays 0 and imem_addr stays constant thereafter.
REQ-036 Out-of-range: redirect_pc=0xFFC with id_ready=1 -> one word is fetched from 0xFFC (NOP 00000000), then fault=1 with fault_pc=0x1000.
REQ-037 Reset mid-stall: pull rst_n low with ifid_valid=1 -> the next edge shows all REQ-030 values, and the first fetch after release is from RESET_PC after one SETTLE cycle.
